// File: rtl/soc_reset_gen.sv
// soc_reset_gen: SoC-wide synchronous reset sequencer.
// Holds sys_rst until PLL lock has been stable for STRETCH_CYCLES, re-asserts
// it on lock loss or a debounced button press, and records cause and count.
module soc_reset_gen #(
  parameter int unsigned STRETCH_CYCLES   = 1024,
  parameter int unsigned DEBOUNCE_CYCLES  = 50000,
  parameter int unsigned LOCK_SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       btn_n,
  output logic       sys_rst,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned ST_W = $clog2(STRETCH_CYCLES + 1);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] STRETCH   = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;
  localparam logic [1:0] HOLD      = 2'd3;

  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_BTN  = 2'd2;

  logic [LOCK_SYNC_STAGES-1:0] lock_sync;
  logic                        lock_s;
  logic [1:0]                  btn_sync;
  logic                        btn_s;
  logic                        btn_db;
  logic [DB_W-1:0]             db_cnt;
  logic [ST_W-1:0]             st_cnt;
  logic [1:0]                  state;
  logic [1:0]                  state_nx;
  logic [1:0]                  cause_nx;
  logic                        count_inc;

  assign lock_s = lock_sync[LOCK_SYNC_STAGES-1];
  assign btn_s  = btn_sync[1];

  // Synchronize PLL lock (resets unlocked) and button (resets released)
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync <= '0;
      btn_sync  <= '1;
    end else begin
      lock_sync <= {lock_sync[LOCK_SYNC_STAGES-2:0], pll_lock};
      btn_sync  <= {btn_sync[0], btn_n};
    end
  end

  // Debounce: accept a new button level once it has differed from btn_db
  // for DEBOUNCE_CYCLES consecutive cycles (the update lands on the edge
  // where the count would reach DEBOUNCE_CYCLES)
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Next-state, cause and count-event decode; a press outranks lock loss
  always_comb begin
    state_nx  = state;
    cause_nx  = rst_cause;
    count_inc = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (!btn_db) begin
          state_nx  = HOLD;
          cause_nx  = CAUSE_BTN;
          count_inc = 1'b1;
        end else if (lock_s) begin
          state_nx = STRETCH;
        end
      end
      STRETCH: begin
        if (!btn_db) begin
          state_nx  = HOLD;
          cause_nx  = CAUSE_BTN;
          count_inc = 1'b1;
        end else if (!lock_s) begin
          state_nx  = WAIT_LOCK;
          cause_nx  = CAUSE_LOCK;
          count_inc = 1'b1;
        end else if (st_cnt == ST_W'(STRETCH_CYCLES - 1)) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (!btn_db) begin
          state_nx  = HOLD;
          cause_nx  = CAUSE_BTN;
          count_inc = 1'b1;
        end else if (!lock_s) begin
          state_nx  = WAIT_LOCK;
          cause_nx  = CAUSE_LOCK;
          count_inc = 1'b1;
        end
      end
      HOLD: begin
        if (btn_db) state_nx = WAIT_LOCK;
      end
      default: state_nx = WAIT_LOCK;
    endcase
  end

  // State, registered reset output (decoded from next state), cause and count
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_LOCK;
      sys_rst   <= 1'b1;
      rst_cause <= 2'd0;
      rst_count <= '0;
    end else begin
      state     <= state_nx;
      sys_rst   <= (state_nx != RUN);
      rst_cause <= cause_nx;
      if (count_inc && (rst_count != 8'hFF)) rst_count <= rst_count + 8'd1;
    end
  end

  // Stretch counter restarts on every STRETCH entry; partial stretches are lost
  always_ff @(posedge clk) begin
    if (rst) begin
      st_cnt <= '0;
    end else if ((state != STRETCH) && (state_nx == STRETCH)) begin
      st_cnt <= '0;
    end else if (state == STRETCH) begin
      st_cnt <= st_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_soc_reset_gen.sv
// tb_soc_reset_gen: scenario tasks push expected {sys_rst, cause, count}
// at absolute edge numbers and pop/compare them as the edges occur.
module tb_soc_reset_gen;

  typedef struct {
    int unsigned at;
    logic [10:0] val;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       btn_n = 1'b1;
  logic       sys_rst;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;
  logic [10:0] obs;

  int unsigned edge_n = 0;
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  exp_t        exp_q[$];

  soc_reset_gen #(
    .STRETCH_CYCLES(16),
    .DEBOUNCE_CYCLES(8),
    .LOCK_SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_lock(pll_lock),
    .btn_n(btn_n),
    .sys_rst(sys_rst),
    .rst_cause(rst_cause),
    .rst_count(rst_count)
  );

  assign obs = {sys_rst, rst_cause, rst_count};

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, got edge=%0d expected finish", edge_n);
    $fatal(1, "timeout");
  end

  function automatic void expect_at(int unsigned at, logic s, logic [1:0] c,
                                    logic [7:0] n, string name);
    exp_t e;
    e.at   = at;
    e.val  = {s, c, n};
    e.name = name;
    exp_q.push_back(e);
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    pll_lock = 1'b0;
    btn_n    = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int unsigned base;
    exp_t e;
    @(negedge clk);
    rst = 1'b1; pll_lock = 1'b0; btn_n = 1'b1;
    base = edge_n;
    for (int unsigned i = 1; i <= 4; i++) expect_at(base + i, 1'b1, 2'd0, 8'd0, "reset_vals");
    while (exp_q.size() != 0) begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL %s edge=%0d got sys_rst=%b cause=%0d count=%0d expected sys_rst=%b cause=%0d count=%0d",
                   e.name, edge_n, obs[10], obs[9:8], obs[7:0], e.val[10], e.val[9:8], e.val[7:0]);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_power_up();
    int unsigned base;
    exp_t e;
    pll_lock = 1'b1;
    base = edge_n;
    expect_at(base + 18, 1'b1, 2'd0, 8'd0, "pwrup_stretch");
    expect_at(base + 19, 1'b0, 2'd0, 8'd0, "pwrup_run");
    while (exp_q.size() != 0) begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL %s edge=%0d got sys_rst=%b cause=%0d count=%0d expected sys_rst=%b cause=%0d count=%0d",
                   e.name, edge_n, obs[10], obs[9:8], obs[7:0], e.val[10], e.val[9:8], e.val[7:0]);
        end
      end
    end
  endtask

  task automatic test_lock_loss_run();
    int unsigned base;
    exp_t e;
    pll_lock = 1'b0;
    base = edge_n;
    expect_at(base + 2, 1'b0, 2'd0, 8'd0, "loss_run_pre");
    expect_at(base + 3, 1'b1, 2'd1, 8'd1, "loss_run_rst");
    while (exp_q.size() != 0) begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL %s edge=%0d got sys_rst=%b cause=%0d count=%0d expected sys_rst=%b cause=%0d count=%0d",
                   e.name, edge_n, obs[10], obs[9:8], obs[7:0], e.val[10], e.val[9:8], e.val[7:0]);
        end
      end
    end
    pll_lock = 1'b1;
    base = edge_n;
    expect_at(base + 18, 1'b1, 2'd1, 8'd1, "loss_run_restretch");
    expect_at(base + 19, 1'b0, 2'd1, 8'd1, "loss_run_recover");
    while (exp_q.size() != 0) begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL %s edge=%0d got sys_rst=%b cause=%0d count=%0d expected sys_rst=%b cause=%0d count=%0d",
                   e.name, edge_n, obs[10], obs[9:8], obs[7:0], e.val[10], e.val[9:8], e.val[7:0]);
        end
      end
    end
  endtask

  task automatic test_lock_glitch();
    int unsigned base;
    exp_t e;
    do_reset();
    pll_lock = 1'b1;
    base = edge_n;
    expect_at(base + 13, 1'b1, 2'd0, 8'd0, "glitch_cnt10");
    expect_at(base + 15, 1'b1, 2'd0, 8'd0, "glitch_pre");
    expect_at(base + 16, 1'b1, 2'd1, 8'd1, "glitch_lost");
    expect_at(base + 18, 1'b1, 2'd1, 8'd1, "glitch_waiting");
    while (exp_q.size() != 0) begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL %s edge=%0d got sys_rst=%b cause=%0d count=%0d expected sys_rst=%b cause=%0d count=%0d",
                   e.name, edge_n, obs[10], obs[9:8], obs[7:0], e.val[10], e.val[9:8], e.val[7:0]);
        end
      end
      if (edge_n - base == 13) pll_lock = 1'b0;
    end
    pll_lock = 1'b1;
    base = edge_n;
    expect_at(base + 18, 1'b1, 2'd1, 8'd1, "glitch_full_stretch");
    expect_at(base + 19, 1'b0, 2'd1, 8'd1, "glitch_run");
    while (exp_q.size() != 0) begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL %s edge=%0d got sys_rst=%b cause=%0d count=%0d expected sys_rst=%b cause=%0d count=%0d",
                   e.name, edge_n, obs[10], obs[9:8], obs[7:0], e.val[10], e.val[9:8], e.val[7:0]);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int unsigned base;
    int unsigned k;
    exp_t e;
    base  = edge_n;
    btn_n = 1'b0;
    for (int unsigned i = 1; i <= 40; i++) expect_at(base + i, 1'b0, 2'd1, 8'd1, "bounce_ignored");
    while (exp_q.size() != 0) begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL %s edge=%0d got sys_rst=%b cause=%0d count=%0d expected sys_rst=%b cause=%0d count=%0d",
                   e.name, edge_n, obs[10], obs[9:8], obs[7:0], e.val[10], e.val[9:8], e.val[7:0]);
        end
      end
      k = edge_n - base;
      btn_n = (k >= 30) || (((k / 3) % 2) == 1);
    end
    btn_n = 1'b1;
  endtask

  task automatic test_button_press();
    int unsigned base;
    exp_t e;
    btn_n = 1'b0;
    base  = edge_n;
    expect_at(base + 10, 1'b0, 2'd1, 8'd1, "press_pre");
    expect_at(base + 11, 1'b1, 2'd2, 8'd2, "press_hold");
    expect_at(base + 30, 1'b1, 2'd2, 8'd2, "press_release_db");
    expect_at(base + 47, 1'b1, 2'd2, 8'd2, "press_stretch");
    expect_at(base + 48, 1'b0, 2'd2, 8'd2, "press_run");
    while (exp_q.size() != 0) begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL %s edge=%0d got sys_rst=%b cause=%0d count=%0d expected sys_rst=%b cause=%0d count=%0d",
                   e.name, edge_n, obs[10], obs[9:8], obs[7:0], e.val[10], e.val[9:8], e.val[7:0]);
        end
      end
      if (edge_n - base == 20) btn_n = 1'b1;
    end
  endtask

  task automatic test_saturation();
    int unsigned base;
    exp_t e;
    do_reset();
    base = edge_n;
    pll_lock = 1'b1;
    expect_at(base + 800,  1'b1, 2'd1, 8'd100, "sat_100");
    expect_at(base + 2032, 1'b1, 2'd1, 8'd254, "sat_254");
    expect_at(base + 2040, 1'b1, 2'd1, 8'd255, "sat_255");
    expect_at(base + 2400, 1'b1, 2'd1, 8'd255, "sat_300_events");
    expect_at(base + 2480, 1'b1, 2'd1, 8'd255, "sat_holds");
    while (exp_q.size() != 0) begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL %s edge=%0d got sys_rst=%b cause=%0d count=%0d expected sys_rst=%b cause=%0d count=%0d",
                   e.name, edge_n, obs[10], obs[9:8], obs[7:0], e.val[10], e.val[9:8], e.val[7:0]);
        end
      end
      pll_lock = (((edge_n - base) % 8) < 4);
    end
  endtask

  task automatic test_reset_priority();
    int unsigned base;
    exp_t e;
    do_reset();
    pll_lock = 1'b1;
    btn_n    = 1'b0;
    base = edge_n;
    expect_at(base + 10, 1'b1, 2'd0, 8'd0, "prio_stretch");
    expect_at(base + 11, 1'b1, 2'd2, 8'd1, "prio_hold");
    expect_at(base + 15, 1'b1, 2'd2, 8'd1, "prio_hold_stay");
    expect_at(base + 16, 1'b1, 2'd0, 8'd0, "prio_rst_wins");
    while (exp_q.size() != 0) begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL %s edge=%0d got sys_rst=%b cause=%0d count=%0d expected sys_rst=%b cause=%0d count=%0d",
                   e.name, edge_n, obs[10], obs[9:8], obs[7:0], e.val[10], e.val[9:8], e.val[7:0]);
        end
      end
      rst = (edge_n - base == 15);
    end
    rst  = 1'b0;
    base = edge_n;
    expect_at(base + 10, 1'b1, 2'd0, 8'd0, "prio_redebounce");
    expect_at(base + 11, 1'b1, 2'd2, 8'd1, "prio_rehold");
    while (exp_q.size() != 0) begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL %s edge=%0d got sys_rst=%b cause=%0d count=%0d expected sys_rst=%b cause=%0d count=%0d",
                   e.name, edge_n, obs[10], obs[9:8], obs[7:0], e.val[10], e.val[9:8], e.val[7:0]);
        end
      end
    end
    btn_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_loss_run();
    test_lock_glitch();
    test_bounce();
    test_button_press();
    test_saturation();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
